// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues word fetches from pc into a small in-order instruction buffer and
// presents the buffer head to decode. Redirects flush the buffer and retarget
// fetch. A misaligned redirect target becomes a single fault entry, and fetch
// then parks until the next redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_npc,
    output logic [31:0] f_instr,
    output logic        f_exception,
    output logic [3:0]  f_ecause,
    output logic [31:0] f_etval
);

    localparam int          PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Fetch pointer and the address held for an outstanding request.
    logic [31:0]      pc_q;
    logic [31:0]      req_addr_q;
    logic             pending_q;
    logic             discard_q;
    logic             halted_q;

    // Instruction buffer: circular storage plus occupancy.
    logic [31:0]      buf_pc    [DEPTH];
    logic [31:0]      buf_instr [DEPTH];
    logic             buf_exc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             has_room;
    logic             fire;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic             misaligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request, handshake and buffer-movement decisions for this cycle.
    // NOTE: every always_comb output gets a default on every path, so no latch is inferred.
    always_comb begin
        has_room   = count_q < CNT_W'(DEPTH);
        // An outstanding request is never retracted, even after a halting redirect.
        imem_valid = rst && (pending_q || (!halted_q && has_room));
        imem_addr  = pending_q ? req_addr_q : pc_q;
        fire       = imem_valid && imem_ready;
        push       = fire && !discard_q && !redirect_en;
        head_valid = rst && (count_q != '0);
        pop        = head_valid && !stall && !redirect_en;
        misaligned = redirect_en && (redirect_pc[1:0] != 2'b00);
    end

    // Control state: pc, request tracking, buffer pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            pending_q  <= 1'b0;
            discard_q  <= 1'b0;
            halted_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect_en) begin
            pc_q     <= redirect_pc;
            rd_ptr_q <= '0;
            if (misaligned) begin
                wr_ptr_q <= PTR_W'(1);
                count_q  <= CNT_W'(1);
                halted_q <= 1'b1;
            end else begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                halted_q <= 1'b0;
            end
            // A request still in flight keeps its address; its data will be dropped.
            if (imem_valid && !imem_ready) begin
                pending_q  <= 1'b1;
                discard_q  <= 1'b1;
                req_addr_q <= imem_addr;
            end else begin
                pending_q <= 1'b0;
                discard_q <= 1'b0;
            end
        end else begin
            if (fire) begin
                pending_q <= 1'b0;
                discard_q <= 1'b0;
            end else if (imem_valid) begin
                pending_q  <= 1'b1;
                req_addr_q <= imem_addr;
            end
            if (push) begin
                pc_q     <= imem_addr + 32'd4;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Buffer payload writes: fetched words, or the fault entry of a misaligned redirect.
    // NOTE: the payload array is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (misaligned) begin
                buf_pc[0]    <= redirect_pc;
                buf_instr[0] <= NOP;
                buf_exc[0]   <= 1'b1;
            end else if (push) begin
                buf_pc[wr_ptr_q]    <= imem_addr;
                buf_instr[wr_ptr_q] <= imem_rdata;
                buf_exc[wr_ptr_q]   <= 1'b0;
            end
        end
    end

    // Present the buffer head to decode; all fields read zero when it is empty.
    always_comb begin
        f_valid     = head_valid;
        f_exception = 1'b0;
        f_pc        = '0;
        f_npc       = '0;
        f_instr     = '0;
        f_ecause    = 4'd0;
        f_etval     = '0;
        if (head_valid) begin
            f_exception = buf_exc[rd_ptr_q];
            f_pc        = buf_pc[rd_ptr_q];
            f_npc       = buf_pc[rd_ptr_q] + 32'd4;
            f_instr     = buf_exc[rd_ptr_q] ? NOP : buf_instr[rd_ptr_q];
            f_etval     = buf_exc[rd_ptr_q] ? buf_pc[rd_ptr_q] : 32'd0;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries; legal values 2..4.
REQ-003 SHALL use reset rst, synchronous, active-low, and clock clk.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 imem_valid  output  1  instruction fetch request active.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_ready  input  1  request completes this cycle; imem_rdata valid.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect_en  input  1  branch/jump/trap redirect from later stages.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 stall  input  1  decode not accepting; hold head entry.
REQ-013 f_valid  output  1  buffer head holds a valid entry.
REQ-014 f_pc  output  32  pc of head entry.
REQ-015 f_npc  output  32  f_pc + 4, modulo 2^32.
REQ-016 f_instr  output  32  instruction of head entry; 32'h0000_0013 (nop) when f_exception=1.
REQ-017 f_exception  output  1  head entry is an instruction-address-misaligned fault.
REQ-018 f_ecause  output  4  4'd0 when f_exception=1, else 0.
REQ-019 f_etval  output  32  faulting pc when f_exception=1, else 0.

Function
REQ-020 SHALL hold fetch pc, a DEPTH-entry FIFO {pc, instr, exception}, count (0..DEPTH), a pending flag (request issued, not yet completed), a discard flag, and a halted flag.
REQ-021 SHALL raise imem_valid when not halted and either pending=1 or registered count < DEPTH; imem_addr = pc.
REQ-022 SHALL keep imem_valid=1 and imem_addr stable from issue until the imem_ready cycle; a request is never retracted.
REQ-023 Handshake: a request completes in any cycle with imem_valid=1 and imem_ready=1, including the issue cycle (zero wait states).
REQ-024 On completion with discard=0 and redirect_en=0: push {pc, imem_rdata, 0}; pc <= pc + 4 (wraps at 2^32).
REQ-025 Latency: an entry pushed in cycle t is visible on f_* in cycle t+1 if the buffer was empty.
REQ-026 Pop when f_valid=1 and stall=0; simultaneous push and pop leaves count unchanged.
REQ-027 f_* SHALL show FIFO head directly; with stall=1 the head and f_* stay unchanged.
REQ-028 Redirect (redirect_en=1) SHALL take priority over push and pop: flush FIFO (count <= 0), pc <= redirect_pc, halted <= 0.
REQ-029 Redirect while a request is outstanding and not completing that cycle: set discard=1; keep old address until imem_ready; drop that response; clear discard; issue at new pc next cycle.
REQ-030 Redirect in the completion cycle: drop the response; next request uses redirect_pc the following cycle.
REQ-031 If redirect_pc[1:0] != 0: push one entry {redirect_pc, nop, 1} without a memory request; halted <= 1; no further requests until the next redirect.
REQ-032 Overflow impossible: issue only with count < DEPTH and at most one outstanding request.
REQ-033 Underflow impossible: pop only when f_valid=1.

Reset
REQ-034 While rst=0: pc <= RESET_PC; count, pending, discard, halted <= 0; imem_valid=0; f_valid=0; f_exception=0; f_pc, f_npc, f_instr, f_ecause, f_etval <= 0.
REQ-035 Reset mid-request SHALL abandon the outstanding request; the memory returns to idle.
REQ-036 First request at RESET_PC in the first cycle after rst=1.

Verification
REQ-037 Zero-wait stream: imem_ready=1 constantly, stall=0, RESET_PC=0 -> f_pc 0,4,8,... one per cycle from cycle 2 after reset release; f_npc = f_pc+4.
REQ-038 Backpressure: stall=1 for 5 cycles -> count reaches DEPTH, imem_valid drops, f_pc frozen; on release no entry lost or duplicated.
REQ-039 Redirect with 3-cycle imem latency: redirect_pc=0x100 one cycle after issue at 0x8 -> imem_addr stays 0x8 until ready, 0x8 data dropped, next imem_addr=0x100, next f_pc=0x100.
REQ-040 Redirect in completion cycle plus buffer full -> buffer empty next cycle, no stale entry reaches f_*.
REQ-041 Misaligned redirect 0x102 -> f_valid=1, f_exception=1, f_ecause=0, f_etval=0x102, imem_valid=0 until redirect to 0x200, which resumes fetch.
REQ-042 Reset asserted mid-request, pc=0x40 -> imem_valid=0 during reset; after release fetch restarts at RESET_PC with empty buffer.
